// File: rtl/nec_ir_receiver.sv
// nec_ir_receiver: decodes a demodulated NEC IR stream into a 32-bit code with valid/repeat/error strobes.
module nec_ir_receiver #(
  parameter int CYCLES_PER_US = 74,
  parameter int TIMEOUT_US    = 12000,
  parameter bit CHECK_INVERSE = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        error_out
);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE} state_t;
  localparam int PW = CYCLES_PER_US > 1 ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CYCLES_PER_US - 1);
  localparam logic [13:0] TO = 14'(TIMEOUT_US);
  state_t state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0] us_q, us_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] shift_q, shift_d, code_q, code_d, word;
  logic have_q, have_d, valid_q, valid_d, rep_q, rep_d, err_q, err_d;
  logic edge_det, fall, rise, us_tick, one_sp, zero_sp, inv_ok, fail;
  function automatic logic win(input logic [13:0] v, input logic [13:0] lo, input logic [13:0] hi);
    return v >= lo && v <= hi;
  endfunction
  assign edge_det = sync2_q != prev_q;
  assign fall = edge_det && !sync2_q;
  assign rise = edge_det && sync2_q;
  assign us_tick = presc_q == PRESC_TOP;
  assign presc_d = (edge_det || us_tick) ? '0 : presc_q + 1'b1;
  assign us_d = edge_det ? '0 : (us_tick && us_q != 14'h3FFF) ? us_q + 14'd1 : us_q;
  assign one_sp = win(us_q, 14'd1400, 14'd1900);
  assign zero_sp = win(us_q, 14'd400, 14'd720);
  assign word = {shift_q[30:0], one_sp};
  assign inv_ok = !CHECK_INVERSE || (word[23:16] == ~word[31:24] && word[7:0] == ~word[15:8]);
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    code_d = code_q;
    have_d = have_q;
    valid_d = 1'b0;
    rep_d = 1'b0;
    fail = 1'b0;
    case (state_q)
      IDLE: state_d = fall ? LEAD_MARK : IDLE;
      LEAD_MARK: if (rise) begin
        fail = !win(us_q, 14'd8000, 14'd10000);
        state_d = LEAD_SPACE;
      end
      LEAD_SPACE: if (fall) begin
        if (win(us_q, 14'd4000, 14'd5000)) begin
          bit_d = '0;
          state_d = BIT_MARK;
        end else if (win(us_q, 14'd1800, 14'd2700)) begin
          rep_d = have_q;
          fail = !have_q;
          state_d = IDLE;
        end else
          fail = 1'b1;
      end
      BIT_MARK: if (rise) begin
        fail = !win(us_q, 14'd400, 14'd720);
        state_d = BIT_SPACE;
      end
      BIT_SPACE: if (fall) begin
        // a completed word is only published once both complement bytes agree
        if (!(one_sp || zero_sp))
          fail = 1'b1;
        else if (bit_q == 5'd31) begin
          shift_d = word;
          fail = !inv_ok;
          code_d = inv_ok ? word : code_q;
          valid_d = inv_ok;
          have_d = have_q || inv_ok;
          state_d = IDLE;
        end else begin
          shift_d = word;
          bit_d = bit_q + 5'd1;
          state_d = BIT_MARK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !edge_det && us_q >= TO)
      fail = 1'b1;
    state_d = fail ? IDLE : state_d;
    err_d = fail;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
      presc_q <= '0;
      us_q <= '0;
      state_q <= IDLE;
      bit_q <= '0;
      shift_q <= '0;
      code_q <= '0;
      have_q <= 1'b0;
      valid_q <= 1'b0;
      rep_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      presc_q <= presc_d;
      us_q <= us_d;
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      code_q <= code_d;
      have_q <= have_d;
      valid_q <= valid_d;
      rep_q <= rep_d;
      err_q <= err_d;
    end
  end
  assign code_out = code_q;
  assign valid_out = valid_q;
  assign repeat_out = rep_q;
  assign error_out = err_q;
endmodule

// File: tb/tb_nec_ir_receiver.sv
// tb_nec_ir_receiver: directed NEC frames, repeats, errors, timeouts and async reset against hand-computed results.
module tb_nec_ir_receiver;
  localparam int CPU = 4;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic ir_in = 1'b1;
  logic [31:0] code_out;
  logic valid_out, repeat_out, error_out;
  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_rep = 0, n_err = 0, n_multi = 0;
  int v0, r0, e0;
  longint cyc = 0, err_cyc = 0, t_edge = 0, t_stop = 0;
  always #5 clk_in = ~clk_in;
  nec_ir_receiver #(.CYCLES_PER_US(CPU), .TIMEOUT_US(12000), .CHECK_INVERSE(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ir_in(ir_in),
    .code_out(code_out), .valid_out(valid_out), .repeat_out(repeat_out), .error_out(error_out)
  );
  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (valid_out) n_valid++;
    if (repeat_out) n_rep++;
    if (error_out) begin
      n_err++;
      err_cyc = cyc;
    end
    if (32'(valid_out) + 32'(repeat_out) + 32'(error_out) > 1) n_multi++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic hold(input logic lvl, input int us);
    ir_in = lvl;
    repeat (us * CPU) @(posedge clk_in);
  endtask
  task automatic snap();
    v0 = n_valid;
    r0 = n_rep;
    e0 = n_err;
  endtask
  task automatic strobes(input string tag, input int v, input int r, input int e);
    chk({tag, "_valid"}, 32'(n_valid - v0), 32'(v));
    chk({tag, "_repeat"}, 32'(n_rep - r0), 32'(r));
    chk({tag, "_error"}, 32'(n_err - e0), 32'(e));
  endtask
  task automatic send_frame(input logic [31:0] w, input int bad_idx, input int bad_us);
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 0; i < 32; i++) begin
      hold(1'b0, 560);
      if (i == bad_idx) begin
        hold(1'b1, bad_us);
        t_stop = cyc;
        hold(1'b0, 560);
        hold(1'b1, 1000);
        return;
      end
      hold(1'b1, w[31-i] ? 1690 : 560);
    end
    t_stop = cyc;
    hold(1'b0, 560);
    hold(1'b1, 1000);
  endtask
  task automatic send_repeat();
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 560);
    hold(1'b1, 1000);
  endtask
  initial begin
    repeat (10) @(posedge clk_in);
    #1;
    chk("rst_code", code_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_repeat", {31'b0, repeat_out}, 32'h0);
    chk("rst_error", {31'b0, error_out}, 32'h0);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    hold(1'b1, 100);
    snap();
    send_frame(32'h20DF5BA4, -1, 0);
    strobes("frame1", 1, 0, 0);
    chk("frame1_code", code_out, 32'h20DF5BA4);
    snap();
    send_repeat();
    strobes("rep1", 0, 1, 0);
    chk("rep1_code", code_out, 32'h20DF5BA4);
    snap();
    send_frame(32'h20DF5BA5, -1, 0);
    strobes("badinv", 0, 0, 1);
    chk("badinv_code", code_out, 32'h20DF5BA4);
    chk("badinv_at_last_fall", {31'b0, err_cyc - t_stop >= 2 && err_cyc - t_stop <= 6}, 32'h1);
    snap();
    send_frame(32'h20DF5BA4, 7, 1000);
    strobes("bit7", 0, 0, 1);
    chk("bit7_at_fall", {31'b0, err_cyc - t_stop >= 2 && err_cyc - t_stop <= 6}, 32'h1);
    snap();
    send_frame(32'h00FF807F, -1, 0);
    strobes("after_bit7", 1, 0, 0);
    chk("after_bit7_code", code_out, 32'h00FF807F);
    snap();
    hold(1'b0, 9000);
    t_edge = cyc;
    hold(1'b1, 15000);
    hold(1'b1, 1000);
    strobes("to_high", 0, 0, 1);
    chk("to_high_time", {31'b0, err_cyc - t_edge >= 47990 && err_cyc - t_edge <= 48020}, 32'h1);
    snap();
    t_edge = cyc;
    hold(1'b0, 15000);
    hold(1'b1, 1000);
    strobes("to_low", 0, 0, 1);
    chk("to_low_time", {31'b0, err_cyc - t_edge >= 47990 && err_cyc - t_edge <= 48020}, 32'h1);
    chk("to_low_code", code_out, 32'h00FF807F);
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 0; i < 10; i++) begin
      hold(1'b0, 560);
      hold(1'b1, 560);
    end
    hold(1'b0, 200);
    #1 rst_in = 1'b0;
    #2;
    chk("arst_code", code_out, 32'h0);
    chk("arst_strobes", {29'b0, valid_out, repeat_out, error_out}, 32'h0);
    ir_in = 1'b1;
    repeat (20) @(posedge clk_in);
    #2 rst_in = 1'b1;
    hold(1'b1, 100);
    snap();
    send_repeat();
    strobes("rep_nocode", 0, 0, 1);
    snap();
    send_frame(32'h20DF5BA4, -1, 0);
    strobes("frame2", 1, 0, 0);
    chk("frame2_code", code_out, 32'h20DF5BA4);
    snap();
    send_repeat();
    strobes("rep2", 0, 1, 0);
    chk("onehot", 32'(n_multi), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
